// File: rtl/param_data_cache_if.sv
`default_nettype none
// ============================================================================
// param_data_cache_if : pipeline data port plus line-wide physical-memory port
// Rev 1.0
// ============================================================================
interface param_data_cache_if #(
   parameter int LW = 256
);
   logic          mem_read;
   logic          mem_write;
   logic [3:0]    mem_byte_enable;
   logic [31:0]   mem_address;
   logic [31:0]   mem_wdata;
   logic [31:0]   mem_rdata;
   logic          mem_resp;
   logic          pmem_read;
   logic          pmem_write;
   logic [31:0]   pmem_address;
   logic [LW-1:0] pmem_wdata;
   logic [LW-1:0] pmem_rdata;
   logic          pmem_resp;

   // master: the surrounding system (requester and backing memory); slave: the cache
   modport master (
      output mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
             pmem_rdata, pmem_resp,
      input  mem_rdata, mem_resp, pmem_read, pmem_write, pmem_address, pmem_wdata
   );

   modport slave (
      input  mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
             pmem_rdata, pmem_resp,
      output mem_rdata, mem_resp, pmem_read, pmem_write, pmem_address, pmem_wdata
   );
endinterface
`default_nettype wire

// File: rtl/param_data_cache.sv
`default_nettype none
// ============================================================================
// param_data_cache : write-back, write-allocate N-way L1 data cache, tree PLRU
// Rev 1.0
// ============================================================================
module param_data_cache #(
   parameter int WAYS       = 4,
   parameter int SETS       = 8,
   parameter int LINE_WORDS = 8
) (
   input  wire               clk,
   input  wire               rst_n,
   param_data_cache_if.slave bus,
   output logic [31:0]       hit_count,
   output logic [31:0]       miss_count
);
   localparam int LW  = 32 * LINE_WORDS;
   localparam int WB  = $clog2(LINE_WORDS);
   localparam int OFF = WB + 2;
   localparam int IDX = $clog2(SETS);
   localparam int TAG = 32 - IDX - OFF;
   localparam int WW  = $clog2(WAYS);

   typedef enum logic [1:0] {IDLE = 2'd0, WRITEBACK = 2'd1, FILL = 2'd2} state_e;

   state_e          state_q, state_d;
   logic [WW-1:0]   victim_q;
   logic            filled_q;

   logic [WAYS-1:0] valid_q [SETS];
   logic [WAYS-1:0] dirty_q [SETS];
   logic [WAYS-1:1] plru_q  [SETS];
   logic [TAG-1:0]  tag_q   [SETS][WAYS];
   logic [LW-1:0]   data_q  [SETS][WAYS];

   logic [TAG-1:0]  req_tag;
   logic [IDX-1:0]  req_idx;
   logic [WB-1:0]   req_word;
   logic            req;
   logic [WAYS-1:0] hit_vec;
   logic            hit;
   logic [WW-1:0]   hit_way, inv_way, plru_way, victim_way;
   logic            inv_found;
   logic [WW:0]     walk, climb;
   logic [WAYS-1:1] plru_upd;
   logic [LW-1:0]   hit_line, merged_line;
   logic [31:0]     hit_word, merged_word;
   logic            do_resp, hit_wr;

   assign req_tag  = bus.mem_address[31 -: TAG];
   assign req_idx  = bus.mem_address[OFF +: IDX];
   assign req_word = bus.mem_address[2 +: WB];
   assign req      = bus.mem_read | bus.mem_write;

   always_comb begin
      hit_vec   = '0;
      hit_way   = '0;
      inv_found = 1'b0;
      inv_way   = '0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         hit_vec[w] = valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag);
         if (hit_vec[w]) hit_way = WW'(w);
         if (!valid_q[req_idx][w]) begin
            inv_found = 1'b1;
            inv_way   = WW'(w);
         end
      end
      hit = |hit_vec;

      // Heap-numbered tree: node n has children 2n/2n+1, leaves are WAYS+way.
      walk = (WW + 1)'(1);
      for (int l = 0; l < WW; l++) walk = {walk[WW-1:0], plru_q[req_idx][walk[WW-1:0]]};
      plru_way   = walk[WW-1:0];
      victim_way = inv_found ? inv_way : plru_way;

      plru_upd = plru_q[req_idx];
      climb    = {1'b1, hit_way};
      for (int l = 0; l < WW; l++) begin
         plru_upd[climb[WW:1]] = ~climb[0];
         climb = climb >> 1;
      end

      hit_line = data_q[req_idx][hit_way];
      hit_word = hit_line[{req_word, 5'b0} +: 32];
      for (int b = 0; b < 4; b++)
         merged_word[8*b +: 8] = bus.mem_byte_enable[b] ? bus.mem_wdata[8*b +: 8] : hit_word[8*b +: 8];
      merged_line = hit_line;
      merged_line[{req_word, 5'b0} +: 32] = merged_word;
   end

   always_comb begin
      state_d          = state_q;
      do_resp          = 1'b0;
      bus.mem_rdata    = '0;
      bus.pmem_read    = 1'b0;
      bus.pmem_write   = 1'b0;
      bus.pmem_address = '0;
      bus.pmem_wdata   = '0;
      case (state_q)
         IDLE: begin
            if (req && hit) begin
               do_resp       = 1'b1;
               bus.mem_rdata = hit_word;
            end else if (req) begin
               state_d = (valid_q[req_idx][victim_way] && dirty_q[req_idx][victim_way]) ? WRITEBACK : FILL;
            end
         end
         WRITEBACK: begin
            bus.pmem_write   = 1'b1;
            bus.pmem_address = {tag_q[req_idx][victim_q], req_idx, OFF'(0)};
            bus.pmem_wdata   = data_q[req_idx][victim_q];
            if (bus.pmem_resp) state_d = FILL;
         end
         FILL: begin
            bus.pmem_read    = 1'b1;
            bus.pmem_address = {req_tag, req_idx, OFF'(0)};
            if (bus.pmem_resp) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.mem_resp = do_resp;
   assign hit_wr       = do_resp & bus.mem_write;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         victim_q   <= '0;
         filled_q   <= 1'b0;
         hit_count  <= '0;
         miss_count <= '0;
         for (int s = 0; s < SETS; s++) begin
            valid_q[s] <= '0;
            dirty_q[s] <= '0;
            plru_q[s]  <= '0;
         end
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && req && !hit) begin
            victim_q   <= victim_way;
            miss_count <= miss_count + 32'd1;
         end
         // The completion that follows a fill is not a genuine hit.
         if (do_resp) begin
            filled_q        <= 1'b0;
            plru_q[req_idx] <= plru_upd;
            if (!filled_q) hit_count <= hit_count + 32'd1;
            if (hit_wr && bus.mem_byte_enable != 4'b0) dirty_q[req_idx][hit_way] <= 1'b1;
         end
         if (state_q == WRITEBACK && bus.pmem_resp) dirty_q[req_idx][victim_q] <= 1'b0;
         if (state_q == FILL && bus.pmem_resp) begin
            valid_q[req_idx][victim_q] <= 1'b1;
            dirty_q[req_idx][victim_q] <= 1'b0;
            filled_q                   <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (state_q == FILL && bus.pmem_resp) begin
         data_q[req_idx][victim_q] <= bus.pmem_rdata;
         tag_q[req_idx][victim_q]  <= req_tag;
      end
      if (hit_wr) data_q[req_idx][hit_way] <= merged_line;
   end
endmodule
`default_nettype wire

// File: tb/tb_param_data_cache.sv
`default_nettype none
// ============================================================================
// tb_param_data_cache : randomized bench with a line-level cache reference model
// Rev 1.0
// ============================================================================
module tb_param_data_cache;
   localparam int WAYS       = 4;
   localparam int SETS       = 8;
   localparam int LINE_WORDS = 8;
   localparam int LW         = 32 * LINE_WORDS;
   localparam int OFF        = 5;
   localparam int IDX        = 3;
   localparam int BUDGET     = 200;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] hit_count, miss_count;
   int          errors = 0;
   int          checks = 0;

   param_data_cache_if #(.LW(LW)) bus ();

   param_data_cache #(.WAYS(WAYS), .SETS(SETS), .LINE_WORDS(LINE_WORDS)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus),
      .hit_count  (hit_count),
      .miss_count (miss_count)
   );

   always #5 clk = ~clk;

   // Backing memory, lazily filled with random lines.
   logic [LW-1:0] mem [int unsigned];

   function automatic logic [LW-1:0] get_line(input logic [31:0] a);
      logic [LW-1:0] l;
      if (!mem.exists(a)) begin
         for (int i = 0; i < LINE_WORDS; i++) l[32*i +: 32] = $urandom;
         mem[a] = l;
      end
      return mem[a];
   endfunction

   typedef struct {
      bit            wr;
      logic [31:0]   addr;
      logic [LW-1:0] data;
   } txn_t;

   txn_t log_q[$];
   int   lat = 0;
   int   pm_wait = 0;
   int   hold_changes = 0;
   int   both_high = 0;
   logic [31:0]   hold_addr;
   logic [LW-1:0] hold_data;

   initial begin
      txn_t t;
      bus.pmem_resp  = 1'b0;
      bus.pmem_rdata = '0;
      forever begin
         @(negedge clk);
         bus.pmem_resp = 1'b0;
         if (rst_n && (bus.pmem_read || bus.pmem_write)) begin
            if (bus.pmem_read && bus.pmem_write) both_high++;
            if (pm_wait == 0) begin
               hold_addr = bus.pmem_address;
               hold_data = bus.pmem_wdata;
            end else if (bus.pmem_address !== hold_addr || bus.pmem_wdata !== hold_data) begin
               hold_changes++;
            end
            if (pm_wait >= lat) begin
               t.wr   = bus.pmem_write;
               t.addr = bus.pmem_address;
               t.data = bus.pmem_write ? bus.pmem_wdata : '0;
               log_q.push_back(t);
               if (bus.pmem_write) mem[bus.pmem_address] = bus.pmem_wdata;
               else bus.pmem_rdata = get_line(bus.pmem_address);
               bus.pmem_resp = 1'b1;
               pm_wait = 0;
            end else begin
               pm_wait++;
            end
         end else begin
            pm_wait = 0;
         end
      end
   end

   // Reference model: lines per set with last-use stamps; PLRU victim found by
   // descending away from the half that holds the most recently used way.
   bit            m_valid [SETS][WAYS];
   bit            m_dirty [SETS][WAYS];
   int unsigned   m_tag   [SETS][WAYS];
   logic [LW-1:0] m_data  [SETS][WAYS];
   longint        m_stamp [SETS][WAYS];
   longint        m_now;
   logic [31:0]   m_hits, m_misses;

   function automatic void model_reset();
      for (int s = 0; s < SETS; s++)
         for (int w = 0; w < WAYS; w++) begin
            m_valid[s][w] = 0;
            m_dirty[s][w] = 0;
            m_stamp[s][w] = 0;
         end
      m_now    = 0;
      m_hits   = 0;
      m_misses = 0;
   endfunction

   function automatic int plru_victim(input int s);
      int lo = 0;
      int size = WAYS;
      int half;
      longint tl, tr;
      while (size > 1) begin
         half = size / 2;
         tl = 0;
         tr = 0;
         for (int i = 0; i < half; i++) begin
            if (m_stamp[s][lo+i] > tl) tl = m_stamp[s][lo+i];
            if (m_stamp[s][lo+half+i] > tr) tr = m_stamp[s][lo+half+i];
         end
         if (tl > tr) lo += half;
         size = half;
      end
      return lo;
   endfunction

   task automatic drive_idle();
      bus.mem_read        = 1'b0;
      bus.mem_write       = 1'b0;
      bus.mem_byte_enable = 4'h0;
      bus.mem_address     = '0;
      bus.mem_wdata       = '0;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0;
      drive_idle();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      log_q.delete();
   endtask

   task automatic access(input logic [31:0] addr, input bit rd, input bit wr,
                         input logic [3:0] be, input logic [31:0] wd,
                         output logic [31:0] rdata_o, output int cyc_o);
      int s, w, way, exp_cyc, cyc, nexp;
      int unsigned t;
      bit miss, exp_wb, got;
      logic [31:0] wb_addr, fill_addr, exp_rd, new_w;
      logic [LW-1:0] wb_data;
      @(negedge clk);
      s = int'((addr >> OFF) % SETS);
      w = int'((addr >> 2) % LINE_WORDS);
      t = addr >> (OFF + IDX);
      way = -1;
      for (int i = 0; i < WAYS; i++) if (m_valid[s][i] && m_tag[s][i] == t) way = i;
      miss      = (way < 0);
      exp_wb    = 0;
      wb_addr   = '0;
      wb_data   = '0;
      fill_addr = addr & 32'hFFFF_FFE0;
      if (miss) begin
         for (int i = WAYS - 1; i >= 0; i--) if (!m_valid[s][i]) way = i;
         if (way < 0) way = plru_victim(s);
         if (m_valid[s][way] && m_dirty[s][way]) begin
            exp_wb  = 1;
            wb_addr = (m_tag[s][way] << (OFF + IDX)) | 32'(s << OFF);
            wb_data = m_data[s][way];
         end
         m_valid[s][way] = 1;
         m_dirty[s][way] = 0;
         m_tag[s][way]   = t;
         m_data[s][way]  = get_line(fill_addr);
         m_misses++;
      end else begin
         m_hits++;
      end
      exp_rd = m_data[s][way][32*w +: 32];
      if (wr) begin
         new_w = exp_rd;
         for (int b = 0; b < 4; b++) if (be[b]) new_w[8*b +: 8] = wd[8*b +: 8];
         m_data[s][way][32*w +: 32] = new_w;
         if (be != 4'h0) m_dirty[s][way] = 1;
      end
      m_now++;
      m_stamp[s][way] = m_now;
      exp_cyc = !miss ? 0 : (exp_wb ? 3 + 2 * lat : 2 + lat);

      log_q.delete();
      bus.mem_read        = rd;
      bus.mem_write       = wr;
      bus.mem_byte_enable = be;
      bus.mem_address     = addr;
      bus.mem_wdata       = wd;
      cyc = 0;
      got = 0;
      while (!got && cyc < BUDGET) begin
         #1;
         if (bus.mem_resp === 1'b1) got = 1;
         else begin
            @(negedge clk);
            cyc++;
         end
      end
      rdata_o = bus.mem_rdata;
      cyc_o   = cyc;
      @(negedge clk);
      drive_idle();

      checks++;
      if (!got) begin
         errors++;
         $display("FAIL resp_timeout addr=%h: no mem_resp within %0d cycles, required one", addr, BUDGET);
      end
      checks++;
      if (got && cyc != exp_cyc) begin
         errors++;
         $display("FAIL latency addr=%h: got %0d cycles, expected %0d", addr, cyc, exp_cyc);
      end
      if (rd) begin
         checks++;
         if (rdata_o !== exp_rd) begin
            errors++;
            $display("FAIL rdata addr=%h: got %h, expected %h", addr, rdata_o, exp_rd);
         end
      end
      nexp = miss ? (exp_wb ? 2 : 1) : 0;
      checks++;
      if (log_q.size() != nexp) begin
         errors++;
         $display("FAIL pmem_txn_count addr=%h: got %0d, expected %0d", addr, log_q.size(), nexp);
      end else if (nexp > 0) begin
         if (exp_wb) begin
            checks++;
            if (!log_q[0].wr || log_q[0].addr !== wb_addr || log_q[0].data !== wb_data) begin
               errors++;
               $display("FAIL writeback addr=%h: got wr=%0d @%h data=%h, expected @%h data=%h",
                        addr, log_q[0].wr, log_q[0].addr, log_q[0].data, wb_addr, wb_data);
            end
         end
         checks++;
         if (log_q[nexp-1].wr || log_q[nexp-1].addr !== fill_addr) begin
            errors++;
            $display("FAIL fill addr=%h: got wr=%0d @%h, expected read @%h",
                     addr, log_q[nexp-1].wr, log_q[nexp-1].addr, fill_addr);
         end
      end
      checks++;
      if (hit_count !== m_hits || miss_count !== m_misses) begin
         errors++;
         $display("FAIL counters addr=%h: got hit=%0d miss=%0d, expected hit=%0d miss=%0d",
                  addr, hit_count, miss_count, m_hits, m_misses);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      lat   = 0;
      drive_idle();
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if (bus.mem_resp !== 1'b0 || bus.pmem_read !== 1'b0 || bus.pmem_write !== 1'b0) begin
         errors++;
         $display("FAIL reset_strobes: got resp=%b rd=%b wr=%b, expected 0 0 0",
                  bus.mem_resp, bus.pmem_read, bus.pmem_write);
      end
      rst_n = 1'b1;
      model_reset();
      @(negedge clk);
      #1;
      checks++;
      if (hit_count !== 32'd0 || miss_count !== 32'd0) begin
         errors++;
         $display("FAIL reset_counters: got hit=%0d miss=%0d, expected 0 0", hit_count, miss_count);
      end
      checks++;
      if (bus.pmem_address !== 32'd0 || bus.pmem_wdata !== '0 || bus.mem_rdata !== 32'd0) begin
         errors++;
         $display("FAIL reset_buses: got paddr=%h rdata=%h, expected 0", bus.pmem_address, bus.mem_rdata);
      end
   endtask

   task automatic test_cold_read();
      logic [LW-1:0] l;
      logic [31:0] rd;
      int cyc;
      l = get_line(32'h0000_0100);
      l[63:32] = 32'hDEAD_BEEF;
      mem[32'h0000_0100] = l;
      access(32'h0000_0104, 1, 0, 4'h0, 32'h0, rd, cyc);
      checks++;
      if (rd !== 32'hDEAD_BEEF || miss_count !== 32'd1 || hit_count !== 32'd0) begin
         errors++;
         $display("FAIL cold_read: got rdata=%h miss=%0d hit=%0d, expected deadbeef 1 0", rd, miss_count, hit_count);
      end
      access(32'h0000_0104, 1, 0, 4'h0, 32'h0, rd, cyc);
      checks++;
      if (cyc != 0 || hit_count !== 32'd1 || log_q.size() != 0) begin
         errors++;
         $display("FAIL repeat_read: got cyc=%0d hit=%0d txns=%0d, expected 0 1 0", cyc, hit_count, log_q.size());
      end
   endtask

   task automatic test_partial_write();
      logic [31:0] rd;
      int cyc;
      access(32'h0000_0104, 0, 1, 4'b0011, 32'h1234_5678, rd, cyc);
      access(32'h0000_0104, 1, 0, 4'h0, 32'h0, rd, cyc);
      checks++;
      if (rd !== 32'hDEAD_5678 || log_q.size() != 0) begin
         errors++;
         $display("FAIL partial_write: got %h txns=%0d, expected dead5678 0", rd, log_q.size());
      end
   endtask

   task automatic test_eviction();
      logic [31:0] rd;
      int cyc;
      apply_reset();
      access(32'h0000_0000, 0, 1, 4'hF, 32'hA5A5_0F0F, rd, cyc);
      access(32'h0000_0100, 1, 0, 4'h0, 32'h0, rd, cyc);
      access(32'h0000_0200, 1, 0, 4'h0, 32'h0, rd, cyc);
      access(32'h0000_0300, 1, 0, 4'h0, 32'h0, rd, cyc);
      access(32'h0000_0400, 1, 0, 4'h0, 32'h0, rd, cyc);
      checks++;
      if (log_q.size() != 2) begin
         errors++;
         $display("FAIL evict_txns: got %0d, expected 2", log_q.size());
      end else if (!log_q[0].wr || log_q[0].addr !== 32'h0 || log_q[0].data[31:0] !== 32'hA5A5_0F0F ||
                   log_q[1].wr || log_q[1].addr !== 32'h400) begin
         errors++;
         $display("FAIL evict_order: got wr=%0d @%h w0=%h then wr=%0d @%h, expected write @0 a5a50f0f then read @400",
                  log_q[0].wr, log_q[0].addr, log_q[0].data[31:0], log_q[1].wr, log_q[1].addr);
      end
   endtask

   task automatic test_fill_stall();
      logic [31:0] rd;
      int cyc;
      apply_reset();
      lat = 20;
      hold_changes = 0;
      access(32'h0000_2044, 1, 0, 4'h0, 32'h0, rd, cyc);
      checks++;
      if (cyc < 20 || hold_changes != 0) begin
         errors++;
         $display("FAIL fill_stall: got cyc=%0d changes=%0d, expected >=20 and 0", cyc, hold_changes);
      end
      lat = 0;
   endtask

   task automatic test_reset_in_writeback();
      logic [31:0] rd;
      int cyc;
      bit seen;
      apply_reset();
      lat = 0;
      access(32'h0000_0000, 0, 1, 4'hF, 32'hCAFE_F00D, rd, cyc);
      access(32'h0000_0100, 1, 0, 4'h0, 32'h0, rd, cyc);
      access(32'h0000_0200, 1, 0, 4'h0, 32'h0, rd, cyc);
      access(32'h0000_0300, 1, 0, 4'h0, 32'h0, rd, cyc);
      lat = 10;
      @(negedge clk);
      bus.mem_read    = 1'b1;
      bus.mem_address = 32'h0000_0400;
      seen = 0;
      cyc  = 0;
      while (!seen && cyc < BUDGET) begin
         #1;
         if (bus.pmem_write === 1'b1) seen = 1;
         else begin
            @(negedge clk);
            cyc++;
         end
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL wb_start: pmem_write not seen, expected a writeback");
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (bus.pmem_write !== 1'b0 || bus.pmem_read !== 1'b0 || bus.mem_resp !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: got wr=%b rd=%b resp=%b, expected 0 0 0",
                  bus.pmem_write, bus.pmem_read, bus.mem_resp);
      end
      drive_idle();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      log_q.delete();
      lat = 1;
      access(32'h0000_0000, 1, 0, 4'h0, 32'h0, rd, cyc);
      checks++;
      if (miss_count !== 32'd1 || log_q.size() != 1 || log_q[0].wr || log_q[0].addr !== 32'h0) begin
         errors++;
         $display("FAIL after_reset: got miss=%0d txns=%0d, expected 1 miss with a read @0", miss_count, log_q.size());
      end
      lat = 0;
   endtask

   task automatic test_be_zero();
      logic [31:0] rd;
      int cyc;
      apply_reset();
      access(32'h0000_0000, 1, 0, 4'h0, 32'h0, rd, cyc);
      access(32'h0000_0008, 0, 1, 4'h0, 32'hFFFF_FFFF, rd, cyc);
      access(32'h0000_0100, 1, 0, 4'h0, 32'h0, rd, cyc);
      access(32'h0000_0200, 1, 0, 4'h0, 32'h0, rd, cyc);
      access(32'h0000_0300, 1, 0, 4'h0, 32'h0, rd, cyc);
      access(32'h0000_0400, 1, 0, 4'h0, 32'h0, rd, cyc);
      checks++;
      if (log_q.size() != 1 || log_q[0].wr) begin
         errors++;
         $display("FAIL be_zero_evict: got %0d txns, expected a single read", log_q.size());
      end
   endtask

   task automatic test_random();
      logic [31:0] rd, addr;
      int cyc, op;
      apply_reset();
      both_high    = 0;
      hold_changes = 0;
      for (int n = 0; n < 300; n++) begin
         lat  = $urandom_range(0, 3);
         addr = (32'($urandom_range(0, 5)) << 8) | (32'($urandom_range(0, 7)) << 5) |
                (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
         op = $urandom_range(0, 3);
         access(addr, op != 2, op >= 2, 4'($urandom), $urandom, rd, cyc);
      end
      checks++;
      if (both_high != 0 || hold_changes != 0) begin
         errors++;
         $display("FAIL pmem_protocol: got both_high=%0d changes=%0d, expected 0 0", both_high, hold_changes);
      end
      lat = 0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_cold_read();
      test_partial_write();
      test_eviction();
      test_fill_stall();
      test_reset_in_writeback();
      test_be_zero();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/param_data_cache.md
# param_data_cache

Parametrised write-back, write-allocate, N-way set-associative L1 data cache between the pipeline's data port and the data side of the arbiter/physical memory. Generalises the fixed two-way data cache: way count, set count and line width are parameters, replacement is tree pseudo-LRU, and hit/miss performance counters are exported. Single-cycle hits; misses stall the requester until writeback (if dirty) and fill complete.

## Interface

- WAYS, 4, associativity; power of two, 2..8
- SETS, 8, number of sets; power of two, 2..256
- LINE_WORDS, 8, 32-bit words per line; power of two, 2..16; line width LW = 32*LINE_WORDS
- Derived: OFF = log2(LINE_WORDS)+2, IDX = log2(SETS), TAG = 32-IDX-OFF

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- mem_read  in  1  load request, held until mem_resp
- mem_write  in  1  store request, held until mem_resp
- mem_byte_enable  in  4  store byte mask
- mem_address  in  32  byte address; bits [1:0] ignored
- mem_wdata  in  32  store data
- mem_rdata  out  32  load data, valid while mem_resp=1
- mem_resp  out  1  one-cycle completion pulse
- pmem_read  out  1  line fill request, held until pmem_resp
- pmem_write  out  1  line writeback request, held until pmem_resp
- pmem_address  out  32  line address, bits [OFF-1:0]=0
- pmem_wdata  out  LW  victim line data
- pmem_rdata  in  LW  fill data, valid with pmem_resp
- pmem_resp  in  1  memory completion pulse
- hit_count  out  32  hits since reset, wraps modulo 2^32
- miss_count  out  32  misses since reset, wraps modulo 2^32

## Operation

- Storage per set: WAYS × {valid, dirty, tag[TAG], data[LW]}; WAYS-1 PLRU bits. Flop arrays, read combinationally.
- Address split: tag=[31:IDX+OFF], index=[IDX+OFF-1:OFF], word=[OFF-1:2].
- States: IDLE, WRITEBACK, FILL.
- IDLE, request present: tag compare in all ways of indexed set.
  - Hit: mem_resp=1 this cycle; read returns selected word; write merges mem_wdata per mem_byte_enable into the word at the edge and sets dirty iff mem_byte_enable≠0. PLRU updated to point away from hit way.
  - Miss: choose victim = lowest-index invalid way, else PLRU victim. Victim valid and dirty → WRITEBACK, else → FILL. miss_count+1 on this transition.
- WRITEBACK: pmem_write=1, pmem_address={victim tag, index, 0}, pmem_wdata=victim line. On pmem_resp → FILL; victim dirty cleared.
- FILL: pmem_read=1, pmem_address={req tag, index, 0}. On pmem_resp: victim way loaded with pmem_rdata, tag written, valid=1, dirty=0 → IDLE.
- Back in IDLE the request hits and completes normally; this completion is not counted in hit_count (a "filled" flag suppresses it, cleared on mem_resp). All other hits increment hit_count.
- mem_read and mem_write both high: treated as a write; mem_rdata still driven with the pre-write word.
- No request: no state change, no counter change, PLRU unchanged.

## Timing

- Reset (async assert): state=IDLE, all valid/dirty/PLRU bits=0, counters=0, filled=0; mem_resp, pmem_read, pmem_write=0 immediately; mem_rdata, pmem_address, pmem_wdata=0. Data/tag arrays need not be cleared.
- Reset mid-miss: transaction aborted, nothing installed, pmem strobes drop asynchronously.
- Hit latency: mem_resp in same cycle the request is first seen in IDLE (combinational from request and arrays).
- Clean miss: resp 1 cycle after the pmem_resp of the fill. Dirty miss: writeback, then fill, then resp.
- pmem_read/pmem_write are never high together; each stays high (address, wdata stable) until the cycle pmem_resp is sampled, then drops next cycle.
- Requester holds address/data/strobes stable until mem_resp; it may issue a new request the cycle after mem_resp.
- pmem_resp outside WRITEBACK/FILL is ignored.

## Test plan

Defaults WAYS=4, SETS=8, LINE_WORDS=8 (OFF=5, IDX=3).
- Cold read 0x0000_0104 with memory line word1=0xDEAD_BEEF → one pmem_read at 0x0000_0100, no pmem_write, mem_rdata=0xDEAD_BEEF; miss_count=1, hit_count=0; repeat read → resp same cycle, hit_count=1.
- Write 0x0000_0104, mask 0b0011, data 0x1234_5678 after above → read returns 0xDEAD_5678, no pmem traffic.
- Fill five tags into set 0 (0x000, 0x100, 0x200, 0x300, 0x400 <<…; addresses 0x0000_0000, 0x0000_0100, 0x0000_0200, 0x0000_0300, 0x0000_0400) with first line dirty and ways 1–3 touched after way 0 → fifth access evicts way 0: pmem_write at 0x0000_0000 with modified line, then pmem_read at 0x0000_0400.
- Hold pmem_resp low 20 cycles in FILL → pmem_read and pmem_address stable for all 20 cycles, mem_resp stays 0.
- Assert rst_n=0 during WRITEBACK → pmem_write drops immediately; after release, read of evicted-victim address misses (valid cleared).
- Write with mem_byte_enable=0 to a clean hit line, then evict → no pmem_write issued.
